// File: rtl/cs_pkg.sv
// Shared definitions for the (2,3) cyclic-shift MDS code: symbol type,
// code geometry, rotation helpers and the decoder state encoding.
package cs_pkg;

    localparam int WIDTH    = 4;
    localparam int K        = 2;
    localparam int N        = 3;
    localparam int SHIFT_D0 = 1;
    localparam int SHIFT_D1 = 2;

    typedef logic [WIDTH-1:0] sym_t;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DECODE  = 2'd1,
        OUTPUT  = 2'd2
    } dec_state_e;

    // Cyclic rotate right within one symbol; the result never grows.
    function automatic sym_t rotr(sym_t v, int unsigned s);
        int unsigned sh;
        sh = s % WIDTH;
        return sym_t'((v >> sh) | (v << (WIDTH - sh)));
    endfunction

    // Cyclic rotate left, the inverse of rotr.
    function automatic sym_t rotl(sym_t v, int unsigned s);
        return rotr(v, WIDTH - (s % WIDTH));
    endfunction

    // Parity produced by the matching encoder.
    function automatic sym_t cs_encode(sym_t d0, sym_t d1);
        return rotr(d0, SHIFT_D0) ^ rotr(d1, SHIFT_D1);
    endfunction

endpackage

// File: rtl/cs_decoder_2_3_if.sv
// Symbol-in / codeword-out bus of the (2,3) decoder, plus its statistics.
// master = channel source and codeword consumer, slave = decoder.
interface cs_decoder_2_3_if #(
    parameter int CNT_W = 16
);
    // symbol input channel
    logic                  sym_valid;
    logic                  sym_ready;
    logic [1:0]            sym_idx;
    cs_pkg::sym_t          sym_data;
    logic                  sym_erased;
    logic                  sym_last;
    // recovered codeword channel
    logic                  out_valid;
    logic                  out_ready;
    cs_pkg::sym_t [1:0]    data_out;
    logic                  out_fail;
    logic [1:0]            out_repaired;
    // statistics
    logic [CNT_W-1:0]      cnt_frames;
    logic [CNT_W-1:0]      cnt_fail;

    modport master (
        output sym_valid, sym_idx, sym_data, sym_erased, sym_last, out_ready,
        input  sym_ready, out_valid, data_out, out_fail, out_repaired,
               cnt_frames, cnt_fail
    );

    modport slave (
        input  sym_valid, sym_idx, sym_data, sym_erased, sym_last, out_ready,
        output sym_ready, out_valid, data_out, out_fail, out_repaired,
               cnt_frames, cnt_fail
    );
endinterface

// File: rtl/cs_erasure_solver_2_3.sv
// Combinational erasure solver: recovers d0/d1 from any two surviving
// symbols of a (2,3) cyclic-shift codeword.
module cs_erasure_solver_2_3
    import cs_pkg::*;
(
    input  sym_t [N-1:0] sym_buf,
    input  logic [N-1:0] present,
    output sym_t [K-1:0] d,
    output logic         fail,
    output logic [K-1:0] repaired
);

    // Pick the repair path from the erasure pattern; data wins over parity.
    always_comb begin
        d        = '0;
        fail     = 1'b0;
        repaired = '0;
        if (present[0] && present[1]) begin
            d[0] = sym_buf[0];
            d[1] = sym_buf[1];
        end else if (present[1] && present[2]) begin
            d[0]     = rotl(sym_buf[2] ^ rotr(sym_buf[1], SHIFT_D1), SHIFT_D0);
            d[1]     = sym_buf[1];
            repaired = 2'b01;
        end else if (present[0] && present[2]) begin
            d[0]     = sym_buf[0];
            d[1]     = rotl(sym_buf[2] ^ rotr(sym_buf[0], SHIFT_D0), SHIFT_D1);
            repaired = 2'b10;
        end else begin
            fail = 1'b1;
        end
    end

endmodule

// File: rtl/cs_decoder_2_3.sv
// (2,3) cyclic-shift erasure decoder: collects one codeword symbol by
// symbol, decodes it in a single cycle and holds the result on a
// valid/ready port while keeping saturating frame/failure counters.
module cs_decoder_2_3
    import cs_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    cs_decoder_2_3_if.slave bus
);

    dec_state_e       state_q, state_d;
    sym_t [N-1:0]     buf_q, buf_d;
    logic [N-1:0]     pres_q, pres_d;
    sym_t [K-1:0]     dout_q, dout_d;
    logic             fail_q, fail_d;
    logic [K-1:0]     rep_q, rep_d;
    logic [CNT_W-1:0] cnt_frames_q, cnt_frames_d;
    logic [CNT_W-1:0] cnt_fail_q, cnt_fail_d;

    sym_t [K-1:0]     sol_d;
    logic             sol_fail;
    logic [K-1:0]     sol_rep;

    cs_erasure_solver_2_3 u_solver (
        .sym_buf  (buf_q),
        .present  (pres_q),
        .d        (sol_d),
        .fail     (sol_fail),
        .repaired (sol_rep)
    );

    // Next-state: collect symbols, latch the solver result, then hand off.
    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        pres_d       = pres_q;
        dout_d       = dout_q;
        fail_d       = fail_q;
        rep_d        = rep_q;
        cnt_frames_d = cnt_frames_q;
        cnt_fail_d   = cnt_fail_q;
        case (state_q)
            COLLECT: begin
                if (bus.sym_valid) begin
                    // idx 3 is reserved: the transfer completes but carries nothing
                    if (bus.sym_idx != 2'd3) begin
                        buf_d[bus.sym_idx]  = bus.sym_data;
                        pres_d[bus.sym_idx] = !bus.sym_erased;
                    end
                    if (bus.sym_last) state_d = DECODE;
                end
            end
            DECODE: begin
                dout_d  = sol_d;
                fail_d  = sol_fail;
                rep_d   = sol_rep;
                state_d = OUTPUT;
            end
            OUTPUT: begin
                if (bus.out_ready) begin
                    pres_d  = '0;
                    state_d = COLLECT;
                    if (cnt_frames_q != '1) cnt_frames_d = cnt_frames_q + CNT_W'(1);
                    if (fail_q && (cnt_fail_q != '1)) cnt_fail_d = cnt_fail_q + CNT_W'(1);
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // State and datapath registers; reset discards any partial codeword.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= COLLECT;
            buf_q        <= '0;
            pres_q       <= '0;
            dout_q       <= '0;
            fail_q       <= 1'b0;
            rep_q        <= '0;
            cnt_frames_q <= '0;
            cnt_fail_q   <= '0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            pres_q       <= pres_d;
            dout_q       <= dout_d;
            fail_q       <= fail_d;
            rep_q        <= rep_d;
            cnt_frames_q <= cnt_frames_d;
            cnt_fail_q   <= cnt_fail_d;
        end
    end

    assign bus.sym_ready    = (state_q == COLLECT);
    assign bus.out_valid    = (state_q == OUTPUT);
    assign bus.data_out     = dout_q;
    assign bus.out_fail     = fail_q;
    assign bus.out_repaired = rep_q;
    assign bus.cnt_frames   = cnt_frames_q;
    assign bus.cnt_fail     = cnt_fail_q;

endmodule

// File: tb/tb_cs_decoder_2_3.sv
// Directed bench for the (2,3) decoder with a brute-force reference model.
module tb_cs_decoder_2_3;

    localparam int CNT_W = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;

    typedef struct {
        int d0;
        int d1;
        int fail;
        int rep;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t q[$];
    int   mf;
    int   mfl;
    int   have[3];
    int   val[3];

    cs_decoder_2_3_if #(.CNT_W(CNT_W)) bus ();

    cs_decoder_2_3 #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int rr(int v, int s);
        return ((v >> s) | (v << (4 - s))) & 15;
    endfunction

    // Reference: search all data pairs for the one consistent with the
    // surviving symbols under the encoder relation.
    function automatic exp_t model(int h0, int h1, int h2, int v0, int v1, int v2);
        exp_t e;
        e.d0 = 0; e.d1 = 0; e.fail = 0; e.rep = 0;
        if (h0 != 0 && h1 != 0) begin
            e.d0 = v0; e.d1 = v1;
        end else if (h0 + h1 + h2 < 2) begin
            e.fail = 1;
        end else begin
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    if ((h0 == 0 || a == v0) && (h1 == 0 || b == v1) &&
                        ((rr(a, 1) ^ rr(b, 2)) == v2)) begin
                        e.d0 = a; e.d1 = b;
                    end
            e.rep = (h0 == 0) ? 1 : 2;
        end
        return e;
    endfunction

    // Every cycle: counters, reset values and any presented codeword.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            mf  = 0;
            mfl = 0;
            chk("rst_out_valid", 32'(bus.out_valid), 0);
            chk("rst_sym_ready", 32'(bus.sym_ready), 1);
            chk("rst_cnt_frames", 32'(bus.cnt_frames), 0);
            chk("rst_data_out", 32'(bus.data_out), 0);
        end else begin
            chk("cnt_frames", 32'(bus.cnt_frames), 32'(mf));
            chk("cnt_fail", 32'(bus.cnt_fail), 32'(mfl));
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", 32'(bus.out_valid), 0);
                end else begin
                    chk("model_d0", 32'(bus.data_out[0]), 32'(q[0].d0));
                    chk("model_d1", 32'(bus.data_out[1]), 32'(q[0].d1));
                    chk("model_fail", 32'(bus.out_fail), 32'(q[0].fail));
                    chk("model_rep", 32'(bus.out_repaired), 32'(q[0].rep));
                    chk("busy_sym_ready", 32'(bus.sym_ready), 0);
                    if (bus.out_ready) begin
                        if (mf < MAXC) mf++;
                        if (q[0].fail != 0 && mfl < MAXC) mfl++;
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    task automatic clear_cw();
        for (int i = 0; i < 3; i++) begin
            have[i] = 0;
            val[i]  = 0;
        end
    endtask

    task automatic send(input int idx, input int data, input int erased, input int last);
        logic acc;
        int   n;
        bus.sym_valid  = 1'b1;
        bus.sym_idx    = 2'(idx);
        bus.sym_data   = 4'(data);
        bus.sym_erased = erased[0];
        bus.sym_last   = last[0];
        n = 0;
        do begin
            @(negedge clk);
            acc = bus.sym_ready;
            @(posedge clk);
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("send_timeout", 32'(acc), 1);
        #1;
        bus.sym_valid = 1'b0;
        if (idx < 3) begin
            have[idx] = (erased == 0) ? 1 : 0;
            val[idx]  = data;
        end
        if (last != 0) begin
            q.push_back(model(have[0], have[1], have[2], val[0], val[1], val[2]));
            clear_cw();
        end
    endtask

    // Literal expectation with the exact two-edge latency after sym_last.
    task automatic expect_out(input string name, input int d0, input int d1,
                              input int fl, input int rep);
        @(negedge clk);
        chk({name, "_decode_gap"}, 32'(bus.out_valid), 0);
        @(negedge clk);
        chk({name, "_valid"}, 32'(bus.out_valid), 1);
        chk({name, "_d0"}, 32'(bus.data_out[0]), 32'(d0));
        chk({name, "_d1"}, 32'(bus.data_out[1]), 32'(d1));
        chk({name, "_fail"}, 32'(bus.out_fail), 32'(fl));
        chk({name, "_rep"}, 32'(bus.out_repaired), 32'(rep));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_cw();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        total = 0; bad = 0; mf = 0; mfl = 0;
        bus.sym_valid = 1'b0; bus.sym_idx = '0; bus.sym_data = '0;
        bus.sym_erased = 1'b0; bus.sym_last = 1'b0; bus.out_ready = 1'b1;
        rst_n = 1'b0;
        clear_cw();
        #1;
        do_reset();

        // clean codeword
        send(0, 3, 0, 0); send(1, 5, 0, 0); send(2, 12, 0, 1);
        expect_out("clean", 3, 5, 0, 0);
        // d0 erased, garbage payload ignored
        send(0, 9, 1, 0); send(1, 5, 0, 0); send(2, 12, 0, 1);
        expect_out("d0_erased", 3, 5, 0, 1);
        // d1 erased
        send(0, 3, 0, 0); send(1, 0, 1, 0); send(2, 12, 0, 1);
        expect_out("d1_erased", 3, 5, 0, 2);
        // double erasure
        send(0, 3, 1, 0); send(1, 5, 1, 0); send(2, 12, 0, 1);
        expect_out("double", 0, 0, 1, 0);
        @(negedge clk);
        chk("cnt_fail_after_double", 32'(bus.cnt_fail), 1);
        chk("cnt_frames_after_four", 32'(bus.cnt_frames), 4);

        // out of order, d0 never sent
        send(2, 12, 0, 0); send(1, 5, 0, 1);
        expect_out("short_ooo", 3, 5, 0, 1);
        // duplicate d1: last write wins
        send(0, 3, 0, 0); send(1, 0, 0, 0); send(1, 5, 0, 0); send(2, 12, 0, 1);
        expect_out("dup_d1", 3, 5, 0, 0);
        // reserved index is a no-op
        send(3, 7, 0, 0); send(0, 3, 0, 0); send(2, 12, 0, 1);
        expect_out("idx3", 3, 5, 0, 2);

        // backpressure with a symbol waiting upstream
        @(posedge clk); #1 bus.out_ready = 1'b0;
        send(0, 6, 0, 0); send(1, 10, 0, 0); send(2, 6, 0, 1);
        expect_out("bp", 6, 10, 0, 0);
        bus.sym_valid = 1'b1; bus.sym_idx = 2'd0; bus.sym_data = 4'd3;
        bus.sym_erased = 1'b0; bus.sym_last = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(bus.out_valid), 1);
            chk("bp_sym_ready", 32'(bus.sym_ready), 0);
            chk("bp_hold_data", 32'(bus.data_out), 32'h0000_00a6);
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
        send(0, 3, 0, 0); send(1, 5, 0, 0); send(2, 12, 0, 1);
        expect_out("after_bp", 3, 5, 0, 0);

        // reset mid-codeword leaves no stale d0
        send(0, 7, 0, 0);
        do_reset();
        send(1, 5, 0, 0); send(2, 12, 0, 1);
        expect_out("post_rst_short", 3, 5, 0, 1);
        send(0, 3, 0, 0); send(1, 5, 0, 0); send(2, 12, 0, 1);
        expect_out("post_rst_full", 3, 5, 0, 0);

        // single-symbol codewords until both counters saturate
        for (int i = 0; i < MAXC + 3; i++) begin
            send(3, 0, 0, 1);
            expect_out("lone_last", 0, 0, 1, 0);
        end
        @(negedge clk);
        chk("sat_cnt_frames", 32'(bus.cnt_frames), 32'(MAXC));
        chk("sat_cnt_fail", 32'(bus.cnt_fail), 32'(MAXC));

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
